dmem_write_buffer: RTL and testbench

- Sits directly downstream of the processor's memory stage, between the core data port and the external data SRAM.
- Posts stores into a small FIFO so the core does not wait on slow memory.
- Services loads with a req/ack handshake, giving loads bypass priority over queued stores when addresses don't conflict.
- Generates byte enables for full-word, store-left and store-right writes.

---
 rtl/dmem_write_buffer_if.sv | 32 +++
 rtl/dmem_write_buffer.sv | 165 ++++++++++++++++
 tb/tb_dmem_write_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_write_buffer_if.sv
// Core-side and external-SRAM-side signals of the data memory write buffer.
// slave is the buffer's view; master is the core/memory environment's view.
interface dmem_write_buffer_if #(
    parameter int unsigned AW = 16
);
    logic [AW-1:0] MemAddr;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   WriteData;
    logic          WriteL;
    logic          WriteR;
    logic [31:0]   MemData;
    logic          MemStall;
    logic          Empty;
    logic [AW-3:0] ExtAddr;
    logic [31:0]   ExtWData;
    logic [3:0]    ExtBE;
    logic          ExtWrite;
    logic          ExtReq;
    logic          ExtAck;
    logic [31:0]   ExtRData;

    modport slave (
        input  MemAddr, MemWrite, MemRead, WriteData, WriteL, WriteR, ExtAck, ExtRData,
        output MemData, MemStall, Empty, ExtAddr, ExtWData, ExtBE, ExtWrite, ExtReq
    );

    modport master (
        output MemAddr, MemWrite, MemRead, WriteData, WriteL, WriteR, ExtAck, ExtRData,
        input  MemData, MemStall, Empty, ExtAddr, ExtWData, ExtBE, ExtWrite, ExtReq
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO between the M stage and external data SRAM; loads bypass
// queued stores unless a queued store targets the same word.
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16
) (
    input logic                 Clock,
    input logic                 nReset,
    dmem_write_buffer_if.slave  bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WaW  = AW - 2;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    logic [WaW-1:0] addr_mem_q [DEPTH];
    logic [31:0]    data_mem_q [DEPTH];
    logic [3:0]     be_mem_q   [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot_off;
    logic [PtrW:0]   count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic            rd_done_q, rd_done_d;
    logic [31:0]     mem_data_q, mem_data_d;
    logic [WaW-1:0]  ext_addr_q, ext_addr_d;
    logic [31:0]     ext_wdata_q, ext_wdata_d;
    logic [3:0]      ext_be_q, ext_be_d;
    logic            ext_write_q, ext_write_d, ext_req_q, ext_req_d;

    logic           full, push, pop, conflict, read_req;
    logic [3:0]     be_new;
    logic [WaW-1:0] word_addr;

    assign word_addr = bus.MemAddr[AW-1:2];
    assign full      = (count_q == (PtrW+1)'(DEPTH));
    assign push      = bus.MemWrite & ~full;
    assign pop       = (state_q == StWrite) & bus.ExtAck;
    // A simultaneous store wins: the load is not seen at all that cycle.
    assign read_req  = bus.MemRead & ~bus.MemWrite & ~rd_done_q;

    always_comb begin
        be_new = 4'b1111;
        if (bus.WriteL & ~bus.WriteR) begin
            be_new = 4'b1111 >> bus.MemAddr[1:0];
        end else if (bus.WriteR & ~bus.WriteL) begin
            be_new = 4'b1111 << (2'd3 - bus.MemAddr[1:0]);
        end
    end

    // Slot i is valid when its distance from the read pointer is below the count.
    always_comb begin
        conflict = 1'b0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PtrW'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < count_q) && (addr_mem_q[i] == word_addr)) begin
                conflict = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push & ~pop) begin
            count_d = count_q + (PtrW+1)'(1);
        end else if (pop & ~push) begin
            count_d = count_q - (PtrW+1)'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_done_d   = 1'b0;
        mem_data_d  = mem_data_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_be_d    = ext_be_q;
        ext_write_d = ext_write_q;
        ext_req_d   = ext_req_q;
        case (state_q)
            StIdle: begin
                if (read_req & ~conflict) begin
                    state_d     = StRead;
                    ext_addr_d  = word_addr;
                    ext_write_d = 1'b0;
                    ext_req_d   = 1'b1;
                end else if (count_q != '0) begin
                    state_d     = StWrite;
                    ext_addr_d  = addr_mem_q[rd_ptr_q];
                    ext_wdata_d = data_mem_q[rd_ptr_q];
                    ext_be_d    = be_mem_q[rd_ptr_q];
                    ext_write_d = 1'b1;
                    ext_req_d   = 1'b1;
                end
            end
            StRead: begin
                if (bus.ExtAck) begin
                    mem_data_d = bus.ExtRData;
                    rd_done_d  = 1'b1;
                    ext_req_d  = 1'b0;
                    state_d    = StIdle;
                end
            end
            StWrite: begin
                if (bus.ExtAck) begin
                    ext_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                ext_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= word_addr;
            data_mem_q[wr_ptr_q] <= bus.WriteData;
            be_mem_q[wr_ptr_q]   <= be_new;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            rd_done_q   <= 1'b0;
            mem_data_q  <= '0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_be_q    <= '0;
            ext_write_q <= 1'b0;
            ext_req_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            rd_done_q   <= rd_done_d;
            mem_data_q  <= mem_data_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_be_q    <= ext_be_d;
            ext_write_q <= ext_write_d;
            ext_req_q   <= ext_req_d;
        end
    end

    assign bus.MemData  = mem_data_q;
    assign bus.MemStall = read_req | (bus.MemWrite & full);
    assign bus.Empty    = (count_q == '0) & (state_q == StIdle);
    assign bus.ExtAddr  = ext_addr_q;
    assign bus.ExtWData = ext_wdata_q;
    assign bus.ExtBE    = ext_be_q;
    assign bus.ExtWrite = ext_write_q;
    assign bus.ExtReq   = ext_req_q;
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: a per-cycle vector table for posted
// stores plus hand-written sequences for full, bypass, RAW and reset cases.
module tb_dmem_write_buffer;
    logic Clock = 1'b0;
    logic nReset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    dmem_write_buffer_if #(.AW(16)) bus ();

    dmem_write_buffer #(.DEPTH(4), .AW(16)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] addr;
        logic        wr, rd, wl, wrr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        stall, empty, req, ewr;
        logic [13:0] eaddr;
        logic [3:0]  be;
        logic [31:0] ewdata;
        logic [31:0] mdata;
        logic        chk_ext;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(logic [15:0] addr, logic wr, logic wl, logic [31:0] wdata,
                                logic ack, logic stall, logic empty, logic req,
                                logic [13:0] eaddr, logic [3:0] be, logic [31:0] ewdata,
                                logic chk_ext);
        vec_t v;
        v.addr = addr; v.wr = wr; v.rd = 1'b0; v.wl = wl; v.wrr = 1'b0;
        v.wdata = wdata; v.ack = ack; v.rdata = 32'h0;
        v.stall = stall; v.empty = empty; v.req = req; v.ewr = req;
        v.eaddr = eaddr; v.be = be; v.ewdata = ewdata; v.mdata = 32'h0;
        v.chk_ext = chk_ext;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.MemAddr = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.WriteData = '0;
        bus.WriteL = 1'b0; bus.WriteR = 1'b0; bus.ExtAck = 1'b0; bus.ExtRData = '0;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        step();
    endtask

    task automatic store(input logic [15:0] addr, input logic [31:0] data,
                         input logic wl, input logic wr);
        bus.MemAddr = addr; bus.MemWrite = 1'b1; bus.WriteData = data;
        bus.WriteL = wl; bus.WriteR = wr;
        step();
        bus.MemWrite = 1'b0; bus.WriteL = 1'b0; bus.WriteR = 1'b0;
    endtask

    // Waits (bounded) for a request; leaves time at the negedge where it was seen.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (bus.ExtReq) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_req: ExtReq got 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic expect_write(input logic [13:0] addr, input logic [3:0] be,
                                input logic [31:0] data);
        bit ok;
        wait_req(ok);
        if (ok) begin
            chk("wr_ExtWrite", 32'(bus.ExtWrite), 32'd1);
            chk("wr_ExtAddr", 32'(bus.ExtAddr), 32'(addr));
            chk("wr_ExtBE", 32'(bus.ExtBE), 32'(be));
            chk("wr_ExtWData", bus.ExtWData, data);
            bus.ExtAck = 1'b1;
            step();
            bus.ExtAck = 1'b0;
        end
    endtask

    logic [3:0] be_l [4];
    logic [3:0] be_r [4];

    initial begin
        clear_inputs();
        be_l[0] = 4'b1111; be_l[1] = 4'b0111; be_l[2] = 4'b0011; be_l[3] = 4'b0001;
        be_r[0] = 4'b1000; be_r[1] = 4'b1100; be_r[2] = 4'b1110; be_r[3] = 4'b1111;

        //            addr     wr  wl  wdata         ack st em rq eaddr   be    ewdata     chk
        vecs[0] = mk(16'h0000, 0, 0, 32'h0,        0, 0, 1, 0, 14'h0, 4'h0, 32'h0,        1);
        vecs[1] = mk(16'h0010, 1, 0, 32'hDEADBEEF, 0, 0, 1, 0, 14'h0, 4'h0, 32'h0,        1);
        vecs[2] = mk(16'h0013, 1, 1, 32'h000000EF, 0, 0, 0, 0, 14'h0, 4'h0, 32'h0,        0);
        vecs[3] = mk(16'h0000, 0, 0, 32'h0,        0, 0, 0, 1, 14'h4, 4'hF, 32'hDEADBEEF, 1);
        vecs[4] = mk(16'h0000, 0, 0, 32'h0,        1, 0, 0, 1, 14'h4, 4'hF, 32'hDEADBEEF, 1);
        vecs[5] = mk(16'h0000, 0, 0, 32'h0,        0, 0, 0, 0, 14'h0, 4'h0, 32'h0,        0);
        vecs[6] = mk(16'h0000, 0, 0, 32'h0,        0, 0, 0, 1, 14'h4, 4'h1, 32'h000000EF, 1);
        vecs[7] = mk(16'h0000, 0, 0, 32'h0,        1, 0, 0, 1, 14'h4, 4'h1, 32'h000000EF, 1);
        vecs[8] = mk(16'h0000, 0, 0, 32'h0,        0, 0, 1, 0, 14'h0, 4'h0, 32'h0,        0);

        do_reset();

        // Posted stores, one vector per clock cycle.
        for (int i = 0; i < 9; i++) begin
            bus.MemAddr = vecs[i].addr; bus.MemWrite = vecs[i].wr; bus.MemRead = vecs[i].rd;
            bus.WriteL = vecs[i].wl; bus.WriteR = vecs[i].wrr; bus.WriteData = vecs[i].wdata;
            bus.ExtAck = vecs[i].ack; bus.ExtRData = vecs[i].rdata;
            @(negedge Clock);
            chk($sformatf("v%0d_MemStall", i), 32'(bus.MemStall), 32'(vecs[i].stall));
            chk($sformatf("v%0d_Empty", i), 32'(bus.Empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d_ExtReq", i), 32'(bus.ExtReq), 32'(vecs[i].req));
            chk($sformatf("v%0d_MemData", i), bus.MemData, vecs[i].mdata);
            if (vecs[i].chk_ext) begin
                chk($sformatf("v%0d_ExtWrite", i), 32'(bus.ExtWrite), 32'(vecs[i].ewr));
                chk($sformatf("v%0d_ExtAddr", i), 32'(bus.ExtAddr), 32'(vecs[i].eaddr));
                chk($sformatf("v%0d_ExtBE", i), 32'(bus.ExtBE), 32'(vecs[i].be));
                chk($sformatf("v%0d_ExtWData", i), bus.ExtWData, vecs[i].ewdata);
            end
            step();
        end
        clear_inputs();

        // Store-left / store-right / both byte enables at each offset.
        for (int j = 0; j < 9; j++) begin
            logic [1:0] o;
            logic [3:0] exp_be;
            o = 2'(j % 4);
            exp_be = (j == 8) ? 4'b1111 : ((j < 4) ? be_l[o] : be_r[o]);
            store(16'h0300 + 16'(o), 32'h100 + 32'(j), (j < 4) || (j == 8), (j >= 4));
            expect_write(14'h00C0, exp_be, 32'h100 + 32'(j));
        end

        // Fill the FIFO with the head write stuck un-acked.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.MemAddr = 16'h0100 + 16'(4 * k); bus.MemWrite = 1'b1;
            bus.WriteData = 32'(k);
            @(negedge Clock);
            chk($sformatf("full_stall_%0d", k), 32'(bus.MemStall), (k == 4) ? 32'd1 : 32'd0);
            step();
        end
        @(negedge Clock);
        chk("full_hold_stall", 32'(bus.MemStall), 32'd1);
        step();
        bus.ExtAck = 1'b1;
        @(negedge Clock);
        chk("full_ack_stall", 32'(bus.MemStall), 32'd1);
        chk("full_head_addr", 32'(bus.ExtAddr), 32'h40);
        step();
        bus.ExtAck = 1'b0;
        @(negedge Clock);
        chk("full_after_pop_stall", 32'(bus.MemStall), 32'd0);
        step();
        bus.MemWrite = 1'b0;
        for (int k = 1; k < 5; k++) expect_write(14'h40 + 14'(k), 4'hF, 32'(k));
        @(negedge Clock);
        chk("full_drained_Empty", 32'(bus.Empty), 32'd1);
        step();

        // Non-conflicting load bypasses a queued store.
        do_reset();
        store(16'h0040, 32'h11111111, 1'b0, 1'b0);
        bus.MemRead = 1'b1; bus.MemAddr = 16'h0080;
        @(negedge Clock);
        chk("byp_stall_req", 32'(bus.MemStall), 32'd1);
        step();
        @(negedge Clock);
        chk("byp_ExtReq", 32'(bus.ExtReq), 32'd1);
        chk("byp_ExtWrite", 32'(bus.ExtWrite), 32'd0);
        chk("byp_ExtAddr", 32'(bus.ExtAddr), 32'h20);
        bus.ExtAck = 1'b1; bus.ExtRData = 32'h12345678;
        step();
        bus.ExtAck = 1'b0;
        @(negedge Clock);
        chk("byp_stall_done", 32'(bus.MemStall), 32'd0);
        chk("byp_MemData", bus.MemData, 32'h12345678);
        chk("byp_req_gap", 32'(bus.ExtReq), 32'd0);
        step();
        bus.MemRead = 1'b0;
        expect_write(14'h10, 4'hF, 32'h11111111);
        @(negedge Clock);
        chk("byp_Empty", 32'(bus.Empty), 32'd1);
        chk("byp_MemData_hold", bus.MemData, 32'h12345678);
        step();

        // Conflicting load waits for the matching store to drain.
        do_reset();
        store(16'h0040, 32'h22222222, 1'b0, 1'b0);
        bus.MemRead = 1'b1; bus.MemAddr = 16'h0042;
        @(negedge Clock);
        chk("raw_stall0", 32'(bus.MemStall), 32'd1);
        step();
        @(negedge Clock);
        chk("raw_first_is_write", 32'(bus.ExtWrite), 32'd1);
        chk("raw_first_req", 32'(bus.ExtReq), 32'd1);
        chk("raw_stall1", 32'(bus.MemStall), 32'd1);
        bus.ExtAck = 1'b1;
        step();
        bus.ExtAck = 1'b0;
        @(negedge Clock);
        chk("raw_gap_req", 32'(bus.ExtReq), 32'd0);
        chk("raw_stall2", 32'(bus.MemStall), 32'd1);
        step();
        @(negedge Clock);
        chk("raw_read_req", 32'(bus.ExtReq), 32'd1);
        chk("raw_read_dir", 32'(bus.ExtWrite), 32'd0);
        chk("raw_read_addr", 32'(bus.ExtAddr), 32'h10);
        chk("raw_stall3", 32'(bus.MemStall), 32'd1);
        bus.ExtAck = 1'b1; bus.ExtRData = 32'hCAFEF00D;
        step();
        bus.ExtAck = 1'b0;
        @(negedge Clock);
        chk("raw_stall_done", 32'(bus.MemStall), 32'd0);
        chk("raw_MemData", bus.MemData, 32'hCAFEF00D);
        step();
        bus.MemRead = 1'b0;

        // Simultaneous load and store is handled as a store.
        do_reset();
        bus.MemRead = 1'b1;
        store(16'h0500, 32'h55, 1'b0, 1'b0);
        bus.MemRead = 1'b0;
        expect_write(14'h140, 4'hF, 32'h55);

        // Asynchronous reset in the middle of a write drops everything.
        do_reset();
        store(16'h0200, 32'hA, 1'b0, 1'b0);
        store(16'h0204, 32'hB, 1'b0, 1'b0);
        begin
            bit ok;
            wait_req(ok);
        end
        #2 nReset = 1'b0;
        #1;
        chk("rst_async_ExtReq", 32'(bus.ExtReq), 32'd0);
        chk("rst_async_Empty", 32'(bus.Empty), 32'd1);
        chk("rst_async_ExtAddr", 32'(bus.ExtAddr), 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            chk($sformatf("rst_idle_req_%0d", c), 32'(bus.ExtReq), 32'd0);
            chk($sformatf("rst_idle_empty_%0d", c), 32'(bus.Empty), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
